// File: rtl/coredefs.sv
// ---------------------------------------------------------------------------
// coredefs -- encodings shared by the ID stage, the ID/EX register and the
// execute stage of the five-stage RV32 pipeline.
//
// Contents:
//   alu_a_sel_e  operand A source  (ALU_A_REG / ALU_A_PC / ALU_A_ZERO)
//   alu_b_sel_e  operand B source  (ALU_B_REG / ALU_B_IMM / ALU_B_FOUR)
//   alu_op_e     ALU operation, RV32I funct3 order
//   ALU_*_EXT    values of ALUext that pick SUB / SRA
//   branch_e     branch / jump kind
// ---------------------------------------------------------------------------
package coredefs;

    localparam int CORE_XLEN = 32;

    typedef enum logic [1:0] {
        ALU_A_REG  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_a_sel_e;

    typedef enum logic [1:0] {
        ALU_B_REG  = 2'd0,
        ALU_B_IMM  = 2'd1,
        ALU_B_FOUR = 2'd2
    } alu_b_sel_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SLL  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SRL  = 3'd5,
        ALU_OR   = 3'd6,
        ALU_AND  = 3'd7
    } alu_op_e;

    localparam logic ALU_SUB_EXT = 1'b1;
    localparam logic ALU_SRA_EXT = 1'b1;

    typedef enum logic [2:0] {
        BRANCH_NIL  = 3'd0,
        BRANCH_JAL  = 3'd1,
        BRANCH_JALR = 3'd2,
        BRANCH_EQ   = 3'd3,
        BRANCH_NE   = 3'd4,
        BRANCH_LT   = 3'd5,
        BRANCH_GE   = 3'd6
    } branch_e;

endpackage

// File: rtl/if_id_ex.sv
// ---------------------------------------------------------------------------
// if_id_ex -- bundle carried by the ID/EX pipeline register.
//
// Modports:
//   out  driven by the ID/EX register
//   in   consumed by the execute stage
// Fields: load/store/writeback controls, memory option, source and
// destination register numbers, ALU operand selects and operation,
// immediate, pc and branch kind.
// ---------------------------------------------------------------------------
interface if_id_ex;
    import coredefs::*;

    logic       mem_load;
    logic       reg_wr;
    logic       mem_wr;
    logic [2:0] mem_opt;
    logic       mem_signed;
    logic [4:0] reg_anum;
    logic [4:0] reg_bnum;
    logic [4:0] reg_wnum;
    alu_a_sel_e alu_sela;
    alu_b_sel_e alu_selb;
    alu_op_e    ALUctr;
    logic       ALUext;
    logic [31:0] imm;
    logic [31:0] pc;
    branch_e    branch;

    modport in (
        input mem_load, reg_wr, mem_wr, mem_opt, mem_signed,
              reg_anum, reg_bnum, reg_wnum, alu_sela, alu_selb,
              ALUctr, ALUext, imm, pc, branch
    );

    modport out (
        output mem_load, reg_wr, mem_wr, mem_opt, mem_signed,
               reg_anum, reg_bnum, reg_wnum, alu_sela, alu_selb,
               ALUctr, ALUext, imm, pc, branch
    );

endinterface

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- purely combinational RV32I integer ALU.
//
// Ports:
//   a, b     in   XLEN  operands
//   ALUctr   in   3     operation, RV32I funct3 order
//   ALUext   in   1     selects SUB (with ADD) or SRA (with SRL)
//   result   out  XLEN  operation result, modulo 2^XLEN
//   zero     out  1     a == b (the comparison a - b is zero)
//   lt       out  1     a < b, signed
//   ltu      out  1     a < b, unsigned
// The three flags describe a versus b regardless of ALUctr so the branch
// unit can use them directly.
// ---------------------------------------------------------------------------
module alu
    import coredefs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      ALUctr,
    input  logic            ALUext,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt,
    output logic            ltu
);

    logic [4:0] shamt;

    assign shamt = b[4:0];
    assign zero  = (a == b);
    assign lt    = ($signed(a) < $signed(b));
    assign ltu   = (a < b);

    // NOTE: every variable written in always_comb is given a default first,
    // so no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        result = '0;
        case (alu_op_e'(ALUctr))
            ALU_ADD:  result = (ALUext == ALU_SUB_EXT) ? (a - b) : (a + b);
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = (ALUext == ALU_SRA_EXT) ? $unsigned($signed(a) >>> shamt)
                                                       : (a >> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the five-stage RV32 pipeline.
//
// Selects ALU operands (with bypassing), runs the ALU, resolves branches and
// jumps into a registered fetch redirect, detects load-use hazards for the
// instruction in ID and registers its results into the EX/MEM boundary.
// Because the redirect is registered, the one wrong-path instruction that
// reaches EX behind a taken branch is squashed via the kill flag.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   ex_in                  if_id_ex.in bundle from the ID/EX register
//   rf_rdata_a/_b          register file data for ex_in.reg_anum/reg_bnum
//   id_anum, id_bnum       source registers of the instruction in ID
//   wb_wr/wb_wnum/wb_wdata writeback port
//   mem_stall              MEM not accepting: freeze every register here
//   stall_req              combinational hazard request to ID/EX and IF/ID
//   redirect_valid/_pc     registered fetch redirect (one cycle per branch)
//   exm_*                  EX/MEM register outputs
//
// Configuration:
//   EX_FORWARD_EN  defined  : EX/MEM -> EX forwarding is built in.
//                  undefined: operands come only from WB bypass / register
//                             file, and stall_req also covers RAW hazards on
//                             the EX and EX/MEM destinations.
// ---------------------------------------------------------------------------
module ex_stage
    import coredefs::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    if_id_ex.in             ex_in,
    input  logic [XLEN-1:0] rf_rdata_a,
    input  logic [XLEN-1:0] rf_rdata_b,
    input  logic [4:0]      id_anum,
    input  logic [4:0]      id_bnum,
    input  logic            wb_wr,
    input  logic [4:0]      wb_wnum,
    input  logic [XLEN-1:0] wb_wdata,
    input  logic            mem_stall,
    output logic            stall_req,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            exm_reg_wr,
    output logic            exm_mem_load,
    output logic            exm_mem_wr,
    output logic            exm_mem_signed,
    output logic [2:0]      exm_mem_opt,
    output logic [4:0]      exm_reg_wnum,
    output logic [XLEN-1:0] exm_alu_res,
    output logic [XLEN-1:0] exm_store_data
);

    logic            kill;
    logic            live;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic            alu_zero;
    logic            alu_lt;
    logic            alu_ltu;
    logic            taken;
    logic            cmp_less;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            load_use;
    logic            hazard;

    // The instruction in EX is real only when the previous cycle did not
    // issue a redirect.
    assign live = ~kill;

    // Source value with priority r0 > EX/MEM (non-load) > WB port > regfile.
    function automatic logic [XLEN-1:0] bypass(input logic [4:0]      num,
                                               input logic [XLEN-1:0] rf_val);
        if (num == 5'd0)
            return '0;
`ifdef EX_FORWARD_EN
        if (exm_reg_wr && !exm_mem_load && (exm_reg_wnum == num))
            return exm_alu_res;
`endif
        if (wb_wr && (wb_wnum == num))
            return wb_wdata;
        return rf_val;
    endfunction

    assign rs1 = bypass(ex_in.reg_anum, rf_rdata_a);
    assign rs2 = bypass(ex_in.reg_bnum, rf_rdata_b);

    always_comb begin
        op_a = rs1;
        case (ex_in.alu_sela)
            ALU_A_REG:  op_a = rs1;
            ALU_A_PC:   op_a = ex_in.pc;
            ALU_A_ZERO: op_a = '0;
            default:    op_a = '0;
        endcase
    end

    always_comb begin
        op_b = rs2;
        case (ex_in.alu_selb)
            ALU_B_REG:  op_b = rs2;
            ALU_B_IMM:  op_b = ex_in.imm;
            ALU_B_FOUR: op_b = XLEN'(4);
            default:    op_b = '0;
        endcase
    end

    alu #(.XLEN(XLEN)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .ALUctr (ex_in.ALUctr),
        .ALUext (ex_in.ALUext),
        .result (alu_res),
        .zero   (alu_zero),
        .lt     (alu_lt),
        .ltu    (alu_ltu)
    );

    // Conditional branches are decoded with both operands from registers, so
    // the ALU's a-versus-b flags compare rs1 with rs2. ALUctr picks signedness.
    assign cmp_less = (ex_in.ALUctr == ALU_SLTU) ? alu_ltu : alu_lt;
    assign jalr_sum = rs1 + ex_in.imm;

    always_comb begin
        taken  = 1'b0;
        target = ex_in.pc + ex_in.imm;
        case (ex_in.branch)
            BRANCH_JAL:  taken = 1'b1;
            BRANCH_JALR: begin
                taken  = 1'b1;
                target = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
            end
            BRANCH_EQ:   taken = alu_zero;
            BRANCH_NE:   taken = ~alu_zero;
            BRANCH_LT:   taken = cmp_less;
            BRANCH_GE:   taken = ~cmp_less;
            default:     taken = 1'b0;
        endcase
    end

    assign load_use = ex_in.mem_load && (ex_in.reg_wnum != 5'd0) &&
                      ((ex_in.reg_wnum == id_anum) || (ex_in.reg_wnum == id_bnum));

`ifdef EX_FORWARD_EN
    assign hazard = load_use;
`else
    // Without forwarding, any pending write to an ID source must drain first.
    assign hazard = load_use ||
                    (ex_in.reg_wr && (ex_in.reg_wnum != 5'd0) &&
                     ((ex_in.reg_wnum == id_anum) || (ex_in.reg_wnum == id_bnum))) ||
                    (exm_reg_wr && (exm_reg_wnum != 5'd0) &&
                     ((exm_reg_wnum == id_anum) || (exm_reg_wnum == id_bnum)));
`endif

    // Gated by rst so every output reads 0 while reset is held, and by kill
    // because a wrong-path instruction must not hold up the pipeline.
    assign stall_req = ~rst & live & hazard;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            exm_reg_wr     <= 1'b0;
            exm_mem_load   <= 1'b0;
            exm_mem_wr     <= 1'b0;
            exm_mem_signed <= 1'b0;
            exm_mem_opt    <= '0;
            exm_reg_wnum   <= '0;
            exm_alu_res    <= '0;
            exm_store_data <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            kill           <= 1'b0;
        end else if (!mem_stall) begin
            exm_reg_wr     <= live & ex_in.reg_wr;
            exm_mem_load   <= live & ex_in.mem_load;
            exm_mem_wr     <= live & ex_in.mem_wr;
            exm_mem_signed <= ex_in.mem_signed;
            exm_mem_opt    <= ex_in.mem_opt;
            exm_reg_wnum   <= ex_in.reg_wnum;
            exm_alu_res    <= alu_res;
            exm_store_data <= rs2;
            redirect_valid <= live & taken;
            redirect_pc    <= target;
            // A redirect marks the next presented instruction as wrong path;
            // a killed instruction never redirects, so kill lasts one cycle.
            kill           <= live & taken;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage.
// Directed scenarios (reset, forwarding, load-use, branch/kill, JALR, freeze,
// back-to-back jumps, reset during stall) followed by randomized instructions.
// Expected values come from a transaction-level reference model below.
// ---------------------------------------------------------------------------
module tb_ex_stage;
    import coredefs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic [4:0]  id_anum, id_bnum;
    logic        wb_wr;
    logic [4:0]  wb_wnum;
    logic [31:0] wb_wdata;
    logic        mem_stall;
    logic        stall_req, redirect_valid;
    logic [31:0] redirect_pc;
    logic        exm_reg_wr, exm_mem_load, exm_mem_wr, exm_mem_signed;
    logic [2:0]  exm_mem_opt;
    logic [4:0]  exm_reg_wnum;
    logic [31:0] exm_alu_res, exm_store_data;

    if_id_ex ex_bus ();

    ex_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_in          (ex_bus),
        .rf_rdata_a     (rf_rdata_a),
        .rf_rdata_b     (rf_rdata_b),
        .id_anum        (id_anum),
        .id_bnum        (id_bnum),
        .wb_wr          (wb_wr),
        .wb_wnum        (wb_wnum),
        .wb_wdata       (wb_wdata),
        .mem_stall      (mem_stall),
        .stall_req      (stall_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exm_reg_wr     (exm_reg_wr),
        .exm_mem_load   (exm_mem_load),
        .exm_mem_wr     (exm_mem_wr),
        .exm_mem_signed (exm_mem_signed),
        .exm_mem_opt    (exm_mem_opt),
        .exm_reg_wnum   (exm_reg_wnum),
        .exm_alu_res    (exm_alu_res),
        .exm_store_data (exm_store_data)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        logic        reg_wr, mem_load, mem_wr, mem_signed;
        logic [2:0]  mem_opt;
        logic [4:0]  wnum;
        logic [31:0] res, sdata;
        bit          bubble;
    } exm_m_t;

    exm_m_t      m_exm, n_exm;
    logic        m_rv, n_rv;
    logic [31:0] m_rpc, n_rpc;
    bit          m_kill, n_kill;
    logic [31:0] rf_mem [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_operand(input logic [4:0] num, input logic [31:0] rf_val);
        if (num == 5'd0) return 32'd0;
`ifdef EX_FORWARD_EN
        if (m_exm.reg_wr && !m_exm.mem_load && m_exm.wnum == num) return m_exm.res;
`endif
        if (wb_wr && wb_wnum == num) return wb_wdata;
        return rf_val;
    endfunction

    function automatic logic [31:0] ref_alu(input alu_op_e op, input logic ext,
                                            input logic [31:0] a, input logic [31:0] b);
        int sh = int'(b % 32);
        case (op)
            ALU_ADD:  return ext ? a - b : a + b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return ext ? 32'($signed(a) >>> sh) : a >> sh;
            ALU_OR:   return a | b;
            default:  return a & b;
        endcase
    endfunction

    function automatic bit ref_taken(input logic [31:0] rs1, input logic [31:0] rs2);
        bit less;
        less = (ex_bus.ALUctr == ALU_SLTU) ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
        case (ex_bus.branch)
            BRANCH_JAL, BRANCH_JALR: return 1'b1;
            BRANCH_EQ: return rs1 == rs2;
            BRANCH_NE: return rs1 != rs2;
            BRANCH_LT: return less;
            BRANCH_GE: return !less;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] rs1);
        if (ex_bus.branch == BRANCH_JALR) return (rs1 + ex_bus.imm) & 32'hFFFF_FFFE;
        return ex_bus.pc + ex_bus.imm;
    endfunction

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && (r == id_anum || r == id_bnum);
    endfunction

    function automatic bit ref_stall();
        bit hz;
        if (rst || m_kill) return 1'b0;
        hz = ex_bus.mem_load && reads(ex_bus.reg_wnum);
`ifndef EX_FORWARD_EN
        if (ex_bus.reg_wr && reads(ex_bus.reg_wnum)) hz = 1'b1;
        if (m_exm.reg_wr && reads(m_exm.wnum)) hz = 1'b1;
`endif
        return hz;
    endfunction

    task automatic model_next();
        logic [31:0] rs1, rs2, a, b;
        bit live;
        if (rst) begin
            n_exm = '{default: 0};
            n_rv = 1'b0; n_rpc = 32'd0; n_kill = 1'b0;
            return;
        end
        n_exm = m_exm; n_rv = m_rv; n_rpc = m_rpc; n_kill = m_kill;
        if (mem_stall) return;
        live = !m_kill;
        rs1 = ref_operand(ex_bus.reg_anum, rf_rdata_a);
        rs2 = ref_operand(ex_bus.reg_bnum, rf_rdata_b);
        case (ex_bus.alu_sela)
            ALU_A_PC:   a = ex_bus.pc;
            ALU_A_ZERO: a = 32'd0;
            default:    a = rs1;
        endcase
        case (ex_bus.alu_selb)
            ALU_B_IMM:  b = ex_bus.imm;
            ALU_B_FOUR: b = 32'd4;
            default:    b = rs2;
        endcase
        n_exm.reg_wr     = live && ex_bus.reg_wr;
        n_exm.mem_load   = live && ex_bus.mem_load;
        n_exm.mem_wr     = live && ex_bus.mem_wr;
        n_exm.mem_signed = ex_bus.mem_signed;
        n_exm.mem_opt    = ex_bus.mem_opt;
        n_exm.wnum       = ex_bus.reg_wnum;
        n_exm.res        = ref_alu(ex_bus.ALUctr, ex_bus.ALUext, a, b);
        n_exm.sdata      = rs2;
        n_exm.bubble     = !live;
        n_rv = live && ref_taken(rs1, rs2);
        if (n_rv) n_rpc = ref_target(rs1);
        n_kill = n_rv;
    endtask

    // ---------------- cycle helpers ----------------
    task automatic settle();
        rf_rdata_a = rf_mem[ex_bus.reg_anum];
        rf_rdata_b = rf_mem[ex_bus.reg_bnum];
        #1;
        check("stall_req", 32'(stall_req), 32'(ref_stall()));
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        m_exm = n_exm; m_rv = n_rv; m_rpc = n_rpc; m_kill = n_kill;
        @(negedge clk);
        check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        if (m_rv) check("redirect_pc", redirect_pc, m_rpc);
        check("exm_reg_wr", 32'(exm_reg_wr), 32'(m_exm.reg_wr));
        check("exm_mem_load", 32'(exm_mem_load), 32'(m_exm.mem_load));
        check("exm_mem_wr", 32'(exm_mem_wr), 32'(m_exm.mem_wr));
        if (!m_exm.bubble) begin
            check("exm_reg_wnum", 32'(exm_reg_wnum), 32'(m_exm.wnum));
            check("exm_alu_res", exm_alu_res, m_exm.res);
            check("exm_store_data", exm_store_data, m_exm.sdata);
            check("exm_mem_opt", 32'(exm_mem_opt), 32'(m_exm.mem_opt));
            check("exm_mem_signed", 32'(exm_mem_signed), 32'(m_exm.mem_signed));
        end
    endtask

    task automatic nop();
        ex_bus.mem_load = 0; ex_bus.reg_wr = 0; ex_bus.mem_wr = 0;
        ex_bus.mem_opt = 3'd0; ex_bus.mem_signed = 0;
        ex_bus.reg_anum = 5'd0; ex_bus.reg_bnum = 5'd0; ex_bus.reg_wnum = 5'd0;
        ex_bus.alu_sela = ALU_A_ZERO; ex_bus.alu_selb = ALU_B_IMM;
        ex_bus.ALUctr = ALU_ADD; ex_bus.ALUext = 1'b0;
        ex_bus.imm = 32'd0; ex_bus.pc = 32'd0; ex_bus.branch = BRANCH_NIL;
        id_anum = 5'd0; id_bnum = 5'd0;
        wb_wr = 1'b0; wb_wnum = 5'd0; wb_wdata = 32'd0;
        mem_stall = 1'b0; rst = 1'b0;
    endtask

    task automatic set_rr(input alu_op_e op, input logic ext, input logic [4:0] rd,
                          input logic [4:0] ra, input logic [4:0] rb);
        nop();
        ex_bus.reg_wr = 1; ex_bus.reg_wnum = rd; ex_bus.reg_anum = ra; ex_bus.reg_bnum = rb;
        ex_bus.alu_sela = ALU_A_REG; ex_bus.alu_selb = ALU_B_REG;
        ex_bus.ALUctr = op; ex_bus.ALUext = ext;
    endtask

    task automatic set_branch(input branch_e br, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd);
        nop();
        ex_bus.branch = br; ex_bus.pc = pc; ex_bus.imm = imm;
        ex_bus.reg_anum = ra; ex_bus.reg_bnum = rb;
        if (br == BRANCH_JAL || br == BRANCH_JALR) begin
            ex_bus.reg_wr = 1; ex_bus.reg_wnum = rd;
            ex_bus.alu_sela = ALU_A_PC; ex_bus.alu_selb = ALU_B_FOUR;
        end else begin
            ex_bus.alu_sela = ALU_A_REG; ex_bus.alu_selb = ALU_B_REG; ex_bus.ALUctr = ALU_SLT;
        end
    endtask

    task automatic rand_instr();
        int kind = int'($urandom_range(0, 7));
        nop();
        ex_bus.reg_anum = 5'($urandom_range(0, 7));
        ex_bus.reg_bnum = 5'($urandom_range(0, 7));
        ex_bus.reg_wnum = 5'($urandom_range(0, 7));
        ex_bus.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom;
        ex_bus.pc = $urandom & 32'hFFFF_FFFC;
        ex_bus.mem_opt = 3'($urandom_range(0, 7));
        ex_bus.mem_signed = 1'($urandom_range(0, 1));
        ex_bus.reg_wr = 1;
        ex_bus.alu_sela = ALU_A_REG; ex_bus.alu_selb = ALU_B_IMM;
        case (kind)
            0, 1, 2: begin
                ex_bus.ALUctr = alu_op_e'(3'($urandom_range(0, 7)));
                ex_bus.ALUext = 1'($urandom_range(0, 1));
                ex_bus.alu_sela = alu_a_sel_e'(2'($urandom_range(0, 2)));
                ex_bus.alu_selb = alu_b_sel_e'(2'($urandom_range(0, 2)));
            end
            3: ex_bus.mem_load = 1;
            4: begin ex_bus.mem_wr = 1; ex_bus.reg_wr = 0; end
            5: begin
                ex_bus.branch = branch_e'(3'($urandom_range(3, 6)));
                ex_bus.reg_wr = 0; ex_bus.alu_selb = ALU_B_REG;
                ex_bus.ALUctr = ($urandom_range(0, 1) == 0) ? ALU_SLT : ALU_SLTU;
            end
            default: begin
                ex_bus.branch = (kind == 6) ? BRANCH_JAL : BRANCH_JALR;
                ex_bus.alu_sela = ALU_A_PC; ex_bus.alu_selb = ALU_B_FOUR;
            end
        endcase
        id_anum = 5'($urandom_range(0, 7));
        id_bnum = 5'($urandom_range(0, 7));
        wb_wr = 1'($urandom_range(0, 1));
        wb_wnum = 5'($urandom_range(0, 7));
        wb_wdata = $urandom;
        mem_stall = ($urandom_range(0, 7) == 0);
        rst = ($urandom_range(0, 63) == 0);
        rf_mem[$urandom_range(0, 7)] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        m_exm = '{default: 0}; m_rv = 1'b0; m_rpc = 32'd0; m_kill = 1'b0;

        // Reset for two cycles with random inputs, including mem_stall.
        for (int i = 0; i < 2; i++) begin
            rand_instr();
            rst = 1'b1;
            settle();
            tick();
        end
        check("rst.alu_res", exm_alu_res, 32'd0);
        check("rst.redirect_pc", redirect_pc, 32'd0);

        // Load-use: load x5 in EX, x5 read in ID; kill must be clear after reset.
        nop(); ex_bus.mem_load = 1; ex_bus.reg_wr = 1; ex_bus.reg_wnum = 5'd5;
        ex_bus.alu_sela = ALU_A_REG; ex_bus.reg_anum = 5'd2; ex_bus.imm = 32'h10;
        id_anum = 5'd5;
        settle();
        check("loaduse.hit", 32'(stall_req), 32'd1);
        tick();
        nop(); ex_bus.mem_load = 1; ex_bus.reg_wr = 1; ex_bus.reg_wnum = 5'd5;
        id_anum = 5'd6;
        settle();
        check("loaduse.miss", 32'(stall_req), 32'd0);
        tick();
        nop(); settle(); tick();

        // Forwarding: x5 = x1 + x2, then x6 = x5 - x1 with x5 stale in the regfile.
        rf_mem[1] = 32'd3; rf_mem[2] = 32'd4; rf_mem[5] = 32'd0;
        set_rr(ALU_ADD, 1'b0, 5'd5, 5'd1, 5'd2);
        id_anum = 5'd5; id_bnum = 5'd1;
        settle();
`ifdef EX_FORWARD_EN
        check("fwd.no_stall", 32'(stall_req), 32'd0);
`else
        check("fwd.raw_stall", 32'(stall_req), 32'd1);
`endif
        tick();
        check("fwd.add", exm_alu_res, 32'd7);
        set_rr(ALU_ADD, ALU_SUB_EXT, 5'd6, 5'd5, 5'd1);
        settle();
        tick();
`ifdef EX_FORWARD_EN
        check("fwd.sub", exm_alu_res, 32'd4);
`else
        check("fwd.sub_stale", exm_alu_res, 32'hFFFF_FFFD);
`endif
        nop(); settle(); tick();

        // Taken BEQ, then the wrong-path ADD x7 is squashed.
        rf_mem[3] = 32'd9; rf_mem[4] = 32'd9;
        set_branch(BRANCH_EQ, 32'h100, 32'h20, 5'd3, 5'd4, 5'd0);
        settle();
        tick();
        check("beq.valid", 32'(redirect_valid), 32'd1);
        check("beq.pc", redirect_pc, 32'h120);
        set_rr(ALU_ADD, 1'b0, 5'd7, 5'd1, 5'd2);
        id_anum = 5'd7;
        settle();
        check("kill.stall", 32'(stall_req), 32'd0);
        tick();
        check("kill.reg_wr", 32'(exm_reg_wr), 32'd0);
        check("kill.redirect", 32'(redirect_valid), 32'd0);

        // JALR: target clears bit 0, rd receives pc+4.
        rf_mem[8] = 32'h1003;
        set_branch(BRANCH_JALR, 32'h200, 32'd0, 5'd8, 5'd0, 5'd1);
        settle();
        tick();
        check("jalr.pc", redirect_pc, 32'h1002);
        check("jalr.link", exm_alu_res, 32'h204);
        nop(); settle(); tick();

        // Freeze with a branch pending in EX: nothing moves until release.
        set_branch(BRANCH_EQ, 32'h300, 32'h40, 5'd3, 5'd4, 5'd0);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            tick();
            check("freeze.hold", 32'(redirect_valid), 32'd0);
        end
        mem_stall = 1'b0;
        settle();
        tick();
        check("freeze.release", 32'(redirect_valid), 32'd1);
        check("freeze.pc", redirect_pc, 32'h340);
        nop(); settle(); tick();
        check("freeze.once", 32'(redirect_valid), 32'd0);

        // Back-to-back jumps: the second is on the wrong path.
        set_branch(BRANCH_JAL, 32'h400, 32'h10, 5'd0, 5'd0, 5'd1);
        settle(); tick();
        check("b2b.first", redirect_pc, 32'h410);
        set_branch(BRANCH_JAL, 32'h404, 32'h80, 5'd0, 5'd0, 5'd1);
        settle(); tick();
        check("b2b.second", 32'(redirect_valid), 32'd0);
        nop(); settle(); tick();

        // Reset asserted while frozen.
        set_rr(ALU_OR, 1'b0, 5'd3, 5'd3, 5'd4);
        settle(); tick();
        rand_instr(); mem_stall = 1'b1; rst = 1'b1;
        settle(); tick();
        check("rststall.reg_wr", 32'(exm_reg_wr), 32'd0);
        check("rststall.res", exm_alu_res, 32'd0);

        // Randomized instruction stream.
        for (int i = 0; i < 400; i++) begin
            rand_instr();
            settle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
